font_rom_arb: RTL and testbench
===============================

FONT_ROM_ARB -- requirements
Module: font_rom_arb

Interface
REQ-001 Parameter ROM_LAT, default 1, font ROM read latency in pclk cycles from address edge to data valid (legal 1..3).
REQ-002 Parameter RR_EN, default 1, 1 = round-robin arbitration, 0 = fixed priority with requester 0 highest.
REQ-003 pclk  input  1  pixel clock; sole clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req0  input  1  requester 0 read request (valid), held with addr0 until granted.
REQ-006 addr0  input  11  requester 0 ROM address {char_code[6:0], char_line[3:0]}.
REQ-007 gnt0  output  1  requester 0 accept (ready), combinational.
REQ-008 data0  output  8  requester 0 returned char_line_pixels, registered.
REQ-009 valid0  output  1  one-cycle pulse, data0 valid.
REQ-010 req1, addr1, gnt1, data1, valid1 SHALL mirror REQ-005..REQ-009 for requester 1.
REQ-011 rom_addr  output  11  registered address to font ROM.
REQ-012 rom_data  input  8  font ROM read data, ROM_LAT cycles after rom_addr.

Function
REQ-013 Transfer occurs on each rising edge where reqX=1 and gntX=1; at most one transfer per edge.
REQ-014 gntX SHALL depend only on req0, req1 and internal registered state; never asserted while reqX=0.
REQ-015 Only one requester: it is granted the same cycle.
REQ-016 Both requesting, RR_EN=1: grant the requester not granted on the most recent transfer; last-granted register updates on every transfer.
REQ-017 Both requesting, RR_EN=0: grant requester 0; requester 1 waits.
REQ-018 On a transfer edge, rom_addr SHALL load the granted address and a 1-bit tag plus issue flag SHALL enter a delay pipeline of depth ROM_LAT.
REQ-019 No transfer: rom_addr holds its value, issue flag of 0 enters the pipeline.
REQ-020 When the pipeline output issue flag is 1, on the next edge dataT <= rom_data and validT <= 1 for the tagged requester T; other requester's valid <= 0.
REQ-021 Latency: validT high exactly ROM_LAT+1 cycles after the transfer edge (2 cycles for ROM_LAT=1).
REQ-022 dataX holds its last value while validX=0.
REQ-023 Back-to-back transfers every cycle SHALL be sustained; returns occur in issue order, one per cycle, no loss or reordering.
REQ-024 Requester may keep reqX high after a transfer to issue the next address; each accepted edge counts as a new read.
REQ-025 valid0 and valid1 SHALL never be high in the same cycle.

Reset
REQ-026 While rst=1: gnt0=gnt1=0 regardless of req, valid0=valid1=0, data0=data1=8'h00, rom_addr=11'h000, all pipeline issue flags 0.
REQ-027 Last-granted register resets to requester 1, so the first tie goes to requester 0.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight reads; no validX pulse for any read accepted before reset.
REQ-029 First transfer possible on the first rising edge after rst deasserts.

Verification
REQ-030 Reset then req0=1, addr0=11'h41A, ROM model returns 8'h3C for 11'h41A -> gnt0=1 same cycle, rom_addr=11'h41A next cycle, valid0=1 with data0=8'h3C exactly 2 cycles after transfer, valid1 stays 0.
REQ-031 RR_EN=1, both req held high 6 cycles, distinct addresses -> grant sequence 0,1,0,1,0,1, six valid pulses in same order with matching data.
REQ-032 RR_EN=0, both req held high 4 cycles -> gnt0=1 all 4 cycles, gnt1=0 throughout, four valid0 pulses.
REQ-033 req1 held continuously with addr stepping 11'h100..11'h10F on each grant -> 16 consecutive valid1 pulses with no gaps, data matching ROM contents in order.
REQ-034 Accept read for requester 0, assert rst one cycle later for 2 cycles -> no valid0 pulse afterwards, all outputs at reset values during rst, next tie after release granted to requester 0.
REQ-035 ROM_LAT=3 build, single read by requester 1 -> valid1 exactly 4 cycles after the transfer edge.

Source files
------------

// File: rtl/font_rom_arb_if.sv
// rtl/font_rom_arb_if.sv - requester handshakes and font ROM port bundle for font_rom_arb
interface font_rom_arb_if;
    logic        req0;
    logic [10:0] addr0;
    logic        gnt0;
    logic [7:0]  data0;
    logic        valid0;
    logic        req1;
    logic [10:0] addr1;
    logic        gnt1;
    logic [7:0]  data1;
    logic        valid1;
    logic [10:0] rom_addr;
    logic [7:0]  rom_data;

    // slave: the arbiter; master: requesters plus the ROM behind rom_addr
    modport slave (
        input  req0, addr0, req1, addr1, rom_data,
        output gnt0, data0, valid0, gnt1, data1, valid1, rom_addr
    );
    modport master (
        output req0, addr0, req1, addr1, rom_data,
        input  gnt0, data0, valid0, gnt1, data1, valid1, rom_addr
    );
endinterface

// File: rtl/font_rom_arb.sv
// rtl/font_rom_arb.sv - two-requester font ROM arbiter with tagged return pipeline
module font_rom_arb #(
    parameter int ROM_LAT = 1,
    parameter bit RR_EN   = 1'b1
) (
    input logic           pclk,
    input logic           rst,
    font_rom_arb_if.slave bus
);
    logic              last_q, last_d;
    logic [10:0]       rom_addr_q, rom_addr_d;
    // index 0 sits alongside rom_addr; indices 1..ROM_LAT cover the ROM latency
    logic [ROM_LAT:0]  iss_q, iss_d;
    logic [ROM_LAT:0]  tag_q, tag_d;
    logic [7:0]        data0_q, data0_d, data1_q, data1_d;
    logic              valid0_q, valid0_d, valid1_q, valid1_d;
    logic              g0, g1, xfer, ret, ret_tag;

    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        if (!rst) begin
            if (bus.req0 && bus.req1) begin
                if (RR_EN && !last_q) g1 = 1'b1;
                else                  g0 = 1'b1;
            end else begin
                g0 = bus.req0;
                g1 = bus.req1;
            end
        end
    end

    assign xfer    = g0 | g1;
    assign ret     = iss_q[ROM_LAT];
    assign ret_tag = tag_q[ROM_LAT];

    always_comb begin
        rom_addr_d = rom_addr_q;
        if (g0)      rom_addr_d = bus.addr0;
        else if (g1) rom_addr_d = bus.addr1;
        last_d   = xfer ? g1 : last_q;
        iss_d    = {iss_q[ROM_LAT-1:0], xfer};
        tag_d    = {tag_q[ROM_LAT-1:0], g1};
        valid0_d = ret & ~ret_tag;
        valid1_d = ret &  ret_tag;
        data0_d  = valid0_d ? bus.rom_data : data0_q;
        data1_d  = valid1_d ? bus.rom_data : data1_q;
    end

    // last-granted resets to requester 1 so the first tie goes to requester 0
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            last_q     <= 1'b1;
            rom_addr_q <= 11'h000;
            iss_q      <= '0;
            tag_q      <= '0;
            data0_q    <= 8'h00;
            data1_q    <= 8'h00;
            valid0_q   <= 1'b0;
            valid1_q   <= 1'b0;
        end else begin
            last_q     <= last_d;
            rom_addr_q <= rom_addr_d;
            iss_q      <= iss_d;
            tag_q      <= tag_d;
            data0_q    <= data0_d;
            data1_q    <= data1_d;
            valid0_q   <= valid0_d;
            valid1_q   <= valid1_d;
        end
    end

    assign bus.gnt0     = g0;
    assign bus.gnt1     = g1;
    assign bus.rom_addr = rom_addr_q;
    assign bus.data0    = data0_q;
    assign bus.data1    = data1_q;
    assign bus.valid0   = valid0_q;
    assign bus.valid1   = valid1_q;
endmodule

// File: tb/tb_font_rom_arb.sv
// tb/tb_font_rom_arb.sv - scoreboard bench for font_rom_arb (RR, fixed priority, ROM_LAT=3)
module tb_font_rom_arb;
    logic pclk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;

    typedef struct {
        int         inst;
        logic       tag;
        logic [7:0] data;
        int         due;
    } exp_t;
    exp_t exp_q[$];

    font_rom_arb_if ifa ();
    font_rom_arb_if ifb ();
    font_rom_arb_if ifc ();

    font_rom_arb #(.ROM_LAT(1), .RR_EN(1'b1)) u_rr (.pclk(pclk), .rst(rst), .bus(ifa));
    font_rom_arb #(.ROM_LAT(1), .RR_EN(1'b0)) u_fp (.pclk(pclk), .rst(rst), .bus(ifb));
    font_rom_arb #(.ROM_LAT(3), .RR_EN(1'b1)) u_l3 (.pclk(pclk), .rst(rst), .bus(ifc));

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    function automatic logic [7:0] rom_f(logic [10:0] a);
        if (a == 11'h41A) return 8'h3C;
        return a[7:0] ^ {a[10:8], 5'h0B};
    endfunction

    logic [7:0] ra_s, rb_s;
    logic [7:0] rc_s [3];
    always @(posedge pclk) begin
        ra_s    <= rom_f(ifa.rom_addr);
        rb_s    <= rom_f(ifb.rom_addr);
        rc_s[0] <= rom_f(ifc.rom_addr);
        rc_s[1] <= rc_s[0];
        rc_s[2] <= rc_s[1];
    end
    assign ifa.rom_data = ra_s;
    assign ifb.rom_data = rb_s;
    assign ifc.rom_data = rc_s[2];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(int inst, logic tag, logic [10:0] addr, int lat);
        exp_t e;
        e.inst = inst;
        e.tag  = tag;
        e.data = rom_f(addr);
        e.due  = cyc + lat + 2;
        exp_q.push_back(e);
    endtask

    task automatic mon(int inst, logic v0, logic v1, logic [7:0] d0, logic [7:0] d1);
        exp_t e;
        if (v0 || v1) begin
            chk("valid_exclusive", {31'd0, v0 & v1}, 32'd0);
            n_assert++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_valid inst=%0d observed=%0d%0d expected=00", inst, v1, v0);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("ret_inst", inst, e.inst);
                chk("ret_tag", {31'd0, v1}, {31'd0, e.tag});
                chk("ret_data", {24'd0, (v1 ? d1 : d0)}, {24'd0, e.data});
                chk("ret_cycle", cyc, e.due);
            end
        end
    endtask

    always @(negedge pclk) begin
        mon(0, ifa.valid0, ifa.valid1, ifa.data0, ifa.data1);
        mon(1, ifb.valid0, ifb.valid1, ifb.data0, ifb.data1);
        mon(2, ifc.valid0, ifc.valid1, ifc.data0, ifc.data1);
    end

    task automatic idle_all();
        ifa.req0 = 1'b0; ifa.req1 = 1'b0;
        ifb.req0 = 1'b0; ifb.req1 = 1'b0;
        ifc.req0 = 1'b0; ifc.req1 = 1'b0;
    endtask

    initial begin
        logic        lm;
        logic        w;
        logic [10:0] a0, a1;

        rst = 1'b1;
        ifa.req0 = 1'b1; ifa.req1 = 1'b1; ifa.addr0 = 11'h7AA; ifa.addr1 = 11'h555;
        ifb.req0 = 1'b1; ifb.req1 = 1'b1; ifb.addr0 = 11'h000; ifb.addr1 = 11'h000;
        ifc.req0 = 1'b1; ifc.req1 = 1'b1; ifc.addr0 = 11'h000; ifc.addr1 = 11'h000;

        @(negedge pclk); #1;
        chk("rst_gnt0", {31'd0, ifa.gnt0}, 32'd0);
        chk("rst_gnt1", {31'd0, ifa.gnt1}, 32'd0);
        chk("rst_fp_gnt0", {31'd0, ifb.gnt0}, 32'd0);
        chk("rst_valid0", {31'd0, ifa.valid0}, 32'd0);
        chk("rst_valid1", {31'd0, ifa.valid1}, 32'd0);
        chk("rst_data0", {24'd0, ifa.data0}, 32'd0);
        chk("rst_data1", {24'd0, ifa.data1}, 32'd0);
        chk("rst_rom_addr", {21'd0, ifa.rom_addr}, 32'd0);
        idle_all();

        // single read right after reset release
        @(negedge pclk);
        rst = 1'b0;
        ifa.req0 = 1'b1; ifa.addr0 = 11'h41A;
        #1;
        chk("single_gnt0", {31'd0, ifa.gnt0}, 32'd1);
        chk("single_gnt1", {31'd0, ifa.gnt1}, 32'd0);
        push(0, 1'b0, 11'h41A, 1);
        @(negedge pclk);
        ifa.req0 = 1'b0;
        #1;
        chk("single_rom_addr", {21'd0, ifa.rom_addr}, 32'h41A);
        repeat (4) @(negedge pclk);

        rst = 1'b1;
        repeat (2) @(negedge pclk);
        rst = 1'b0;

        // round-robin tie for six cycles
        lm = 1'b1; a0 = 11'h200; a1 = 11'h300;
        for (int i = 0; i < 6; i++) begin
            @(negedge pclk);
            ifa.req0 = 1'b1; ifa.req1 = 1'b1; ifa.addr0 = a0; ifa.addr1 = a1;
            #1;
            w = ~lm;
            chk("rr_gnt0", {31'd0, ifa.gnt0}, {31'd0, ~w});
            chk("rr_gnt1", {31'd0, ifa.gnt1}, {31'd0, w});
            push(0, w, w ? a1 : a0, 1);
            if (w) a1 = a1 + 11'd1; else a0 = a0 + 11'd1;
            lm = w;
        end
        @(negedge pclk);
        idle_all();
        repeat (4) @(negedge pclk);

        // requester 1 streaming 16 back-to-back reads
        a1 = 11'h100;
        for (int i = 0; i < 16; i++) begin
            @(negedge pclk);
            ifa.req1 = 1'b1; ifa.addr1 = a1;
            #1;
            chk("stream_gnt1", {31'd0, ifa.gnt1}, 32'd1);
            push(0, 1'b1, a1, 1);
            a1 = a1 + 11'd1;
        end
        @(negedge pclk);
        idle_all();
        repeat (4) @(negedge pclk);

        // reset with a read in flight: that read must never return
        @(negedge pclk);
        ifa.req0 = 1'b1; ifa.addr0 = 11'h055;
        #1;
        chk("abort_gnt0", {31'd0, ifa.gnt0}, 32'd1);
        @(negedge pclk);
        rst = 1'b1;
        ifa.req0 = 1'b1; ifa.req1 = 1'b1; ifa.addr0 = 11'h066; ifa.addr1 = 11'h077;
        #1;
        chk("abort_rst_gnt0", {31'd0, ifa.gnt0}, 32'd0);
        chk("abort_rst_gnt1", {31'd0, ifa.gnt1}, 32'd0);
        chk("abort_rst_data1", {24'd0, ifa.data1}, 32'd0);
        chk("abort_rst_rom_addr", {21'd0, ifa.rom_addr}, 32'd0);
        @(negedge pclk); #1;
        chk("abort_rst_valid0", {31'd0, ifa.valid0}, 32'd0);
        chk("abort_rst_data0", {24'd0, ifa.data0}, 32'd0);
        @(negedge pclk);
        rst = 1'b0;
        #1;
        chk("abort_tie_gnt0", {31'd0, ifa.gnt0}, 32'd1);
        chk("abort_tie_gnt1", {31'd0, ifa.gnt1}, 32'd0);
        push(0, 1'b0, 11'h066, 1);
        @(negedge pclk);
        idle_all();
        repeat (6) @(negedge pclk);

        // fixed priority: requester 1 starves
        a0 = 11'h3F0;
        for (int i = 0; i < 4; i++) begin
            @(negedge pclk);
            ifb.req0 = 1'b1; ifb.req1 = 1'b1; ifb.addr0 = a0; ifb.addr1 = 11'h7FF;
            #1;
            chk("fp_gnt0", {31'd0, ifb.gnt0}, 32'd1);
            chk("fp_gnt1", {31'd0, ifb.gnt1}, 32'd0);
            push(1, 1'b0, a0, 1);
            a0 = a0 + 11'd1;
        end
        @(negedge pclk);
        idle_all();
        repeat (4) @(negedge pclk);

        // ROM_LAT=3 single read by requester 1
        @(negedge pclk);
        ifc.req1 = 1'b1; ifc.addr1 = 11'h123;
        #1;
        chk("lat3_gnt1", {31'd0, ifc.gnt1}, 32'd1);
        push(2, 1'b1, 11'h123, 3);
        @(negedge pclk);
        idle_all();
        repeat (8) @(negedge pclk);

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
